// File: rtl/pwm_duty_slew_limiter.sv
// ---------------------------------------------------------------------------
// pwm_duty_slew_limiter
//
// Soft-start / slew limiter between the SPI register bank's duty register
// and the PWM peripheral's duty input.  With ramp_en=1 the applied duty walks
// toward target_duty by STEP every TICK_DIV clocks.  With ramp_en=0 the
// target is applied with one clock of latency.
//
// Ports:
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   target_duty  in   [7:0] requested duty (already in clk domain)
//   ramp_en      in   1 = slew-limited, 0 = pass-through
//   tick_div     in   [CNT_W-1:0] runtime clocks-per-step (only when
//                     SLEW_TICK_EXT_EN is defined; 0 behaves as 1)
//   duty_out     out  [7:0] applied duty
//   ramping      out  high while a ramp is in progress (state != IDLE)
//   ramp_done    out  one-clock pulse when a ramp lands on the target
//
// Build option:
//   SLEW_TICK_EXT_EN - adds the tick_div port, replacing TICK_DIV.
// ---------------------------------------------------------------------------
module pwm_duty_slew_limiter #(
    parameter logic [7:0]  STEP       = 8'd1,
    parameter int unsigned TICK_DIV   = 1000,
    parameter int unsigned CNT_W      = 16,
    parameter logic [7:0]  RESET_DUTY = 8'h00
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       target_duty,
    input  logic             ramp_en,
`ifdef SLEW_TICK_EXT_EN
    input  logic [CNT_W-1:0] tick_div,
`endif
    output logic [7:0]       duty_out,
    output logic             ramping,
    output logic             ramp_done
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] UP   = 2'd1;
    localparam logic [1:0] DOWN = 2'd2;

    logic [1:0]       state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [7:0]       duty_n;
    logic             done_n;
    logic [CNT_W-1:0] div_m1;
    logic             tick;
    logic [8:0]       up_gap, dn_gap, step_w;
    logic [1:0]       dir;

`ifdef SLEW_TICK_EXT_EN
    logic [CNT_W-1:0] div_q;
    logic [CNT_W-1:0] div_in;
    logic             load_div;

    assign div_in   = (tick_div == '0) ? CNT_W'(1) : tick_div;
    assign div_m1   = div_q - CNT_W'(1);
    // Reload the divisor when a ramp starts and on every step.
    assign load_div = ((state == IDLE) && (state_n != IDLE)) ||
                      ((state != IDLE) && tick);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            div_q <= CNT_W'(1);
        else if (load_div)
            div_q <= div_in;
    end
`else
    assign div_m1 = CNT_W'(TICK_DIV - 1);
`endif

    assign tick    = (state != IDLE) && (cnt == div_m1);
    assign up_gap  = {1'b0, target_duty} - {1'b0, duty_out};
    assign dn_gap  = {1'b0, duty_out} - {1'b0, target_duty};
    assign step_w  = {1'b0, STEP};
    assign ramping = (state != IDLE);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        duty_n  = duty_out;
        done_n  = 1'b0;
        dir     = state;

        case (state)
            IDLE: begin
                cnt_n = '0;
                if (!ramp_en)
                    duty_n = target_duty;
                else if (target_duty > duty_out)
                    state_n = UP;
                else if (target_duty < duty_out)
                    state_n = DOWN;
            end
            default: begin
                if (!ramp_en) begin
                    duty_n  = target_duty;
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (target_duty == duty_out) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    done_n  = 1'b1;
                end else begin
                    // Direction is re-evaluated every clock so a target
                    // change reverses the ramp without restarting the tick.
                    dir     = (target_duty > duty_out) ? UP : DOWN;
                    state_n = dir;
                    if (tick) begin
                        cnt_n = '0;
                        if (dir == UP) begin
                            if (up_gap <= step_w) begin
                                duty_n  = target_duty;
                                state_n = IDLE;
                                done_n  = 1'b1;
                            end else begin
                                duty_n = duty_out + STEP;
                            end
                        end else begin
                            if (dn_gap <= step_w) begin
                                duty_n  = target_duty;
                                state_n = IDLE;
                                done_n  = 1'b1;
                            end else begin
                                duty_n = duty_out - STEP;
                            end
                        end
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            duty_out  <= RESET_DUTY;
            ramp_done <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            duty_out  <= duty_n;
            ramp_done <= done_n;
        end
    end

endmodule

// File: tb/tb_pwm_duty_slew_limiter.sv
module tb_pwm_duty_slew_limiter;

    logic        clk;
    logic        rst_n;
    logic [7:0]  target_duty;
    logic        ramp_en;
    logic [7:0]  duty_out;
    logic        ramping;
    logic        ramp_done;
`ifdef SLEW_TICK_EXT_EN
    logic [15:0] tick_div;
`endif

    int n_assert;
    int n_fail;

    pwm_duty_slew_limiter #(
        .STEP       (8'd16),
        .TICK_DIV   (4),
        .CNT_W      (16),
        .RESET_DUTY (8'h00)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .target_duty (target_duty),
        .ramp_en     (ramp_en),
`ifdef SLEW_TICK_EXT_EN
        .tick_div    (tick_div),
`endif
        .duty_out    (duty_out),
        .ramping     (ramping),
        .ramp_done   (ramp_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [7:0] d, input logic r, input logic p);
        chk({tag, ".duty"}, {8'h00, duty_out}, {8'h00, d});
        chk({tag, ".ramping"}, {15'h0, ramping}, {15'h0, r});
        chk({tag, ".done"}, {15'h0, ramp_done}, {15'h0, p});
    endtask

    initial begin
        n_assert    = 0;
        n_fail      = 0;
        rst_n       = 1'b1;
        ramp_en     = 1'b0;
        target_duty = 8'h80;
`ifdef SLEW_TICK_EXT_EN
        tick_div    = 16'd4;
`endif
        #1 rst_n = 1'b0;
        #1 chk_all("reset", 8'h00, 1'b0, 1'b0);
        step(3);
        chk_all("reset_hold", 8'h00, 1'b0, 1'b0);

        // 1: release with ramp_en=1, target 0 -> nothing moves
        ramp_en     = 1'b1;
        target_duty = 8'h00;
        rst_n       = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(1);
            chk_all("post_reset_idle", 8'h00, 1'b0, 1'b0);
        end

        // 2: pass-through, 1 clock latency
        ramp_en     = 1'b0;
        target_duty = 8'h80;
        chk_all("pt_before", 8'h00, 1'b0, 1'b0);
        step(1);
        chk_all("pt_0x80", 8'h80, 1'b0, 1'b0);
        target_duty = 8'h00;
        step(1);
        chk_all("pt_0x00", 8'h00, 1'b0, 1'b0);

        // 3: ramp 0x00 -> 0x40
        ramp_en     = 1'b1;
        target_duty = 8'h40;
        step(1);
        chk_all("up_enter", 8'h00, 1'b1, 1'b0);
        step(3);
        chk_all("up_pre_tick", 8'h00, 1'b1, 1'b0);
        step(1);
        chk_all("up_10", 8'h10, 1'b1, 1'b0);
        step(4);
        chk_all("up_20", 8'h20, 1'b1, 1'b0);
        step(4);
        chk_all("up_30", 8'h30, 1'b1, 1'b0);
        step(4);
        chk_all("up_40_done", 8'h40, 1'b0, 1'b1);
        step(1);
        chk_all("up_after", 8'h40, 1'b0, 1'b0);

        // 4a: partial last step 0x00 -> 0x25
        ramp_en     = 1'b0;
        target_duty = 8'h00;
        step(1);
        ramp_en     = 1'b1;
        target_duty = 8'h25;
        step(1);
        step(4);
        chk_all("p_10", 8'h10, 1'b1, 1'b0);
        step(4);
        chk_all("p_20", 8'h20, 1'b1, 1'b0);
        step(4);
        chk_all("p_25_done", 8'h25, 1'b0, 1'b1);
        step(1);
        chk_all("p_after", 8'h25, 1'b0, 1'b0);

        // 4b: 0xF8 -> 0xFF, no wrap
        ramp_en     = 1'b0;
        target_duty = 8'hF8;
        step(1);
        ramp_en     = 1'b1;
        target_duty = 8'hFF;
        step(1);
        chk_all("top_enter", 8'hF8, 1'b1, 1'b0);
        step(4);
        chk_all("top_ff", 8'hFF, 1'b0, 1'b1);

        // 4c: 0x05 -> 0x00, no underflow
        ramp_en     = 1'b0;
        target_duty = 8'h05;
        step(1);
        ramp_en     = 1'b1;
        target_duty = 8'h00;
        step(1);
        chk_all("bot_enter", 8'h05, 1'b1, 1'b0);
        step(4);
        chk_all("bot_00", 8'h00, 1'b0, 1'b1);
        step(1);

        // 5: reversal mid-ramp with counter preserved
        target_duty = 8'h40;
        step(1);
        step(12);
        chk_all("rev_30", 8'h30, 1'b1, 1'b0);
        target_duty = 8'h10;
        step(1);
        chk_all("rev_dn_enter", 8'h30, 1'b1, 1'b0);
        step(3);
        chk_all("rev_20", 8'h20, 1'b1, 1'b0);
        step(4);
        chk_all("rev_10_done", 8'h10, 1'b0, 1'b1);
        step(1);
        chk_all("rev_after", 8'h10, 1'b0, 1'b0);

        // 5b: target meets duty mid-ramp -> done, no duty change
        target_duty = 8'h40;
        step(1);
        step(4);
        chk_all("meet_20", 8'h20, 1'b1, 1'b0);
        target_duty = 8'h20;
        step(1);
        chk_all("meet_done", 8'h20, 1'b0, 1'b1);
        step(1);

        // 6a: ramp_en drops mid-ramp -> jump, no done
        target_duty = 8'h80;
        step(1);
        step(4);
        chk_all("abort_30", 8'h30, 1'b1, 1'b0);
        ramp_en     = 1'b0;
        target_duty = 8'h90;
        step(1);
        chk_all("abort_90", 8'h90, 1'b0, 1'b0);
        step(1);
        chk_all("abort_after", 8'h90, 1'b0, 1'b0);

        // 6b: async reset mid-ramp
        ramp_en     = 1'b1;
        target_duty = 8'h00;
        step(1);
        step(4);
        chk_all("rst_mid_80", 8'h80, 1'b1, 1'b0);
        step(2);
        #2 rst_n = 1'b0;
        #1 chk_all("rst_async", 8'h00, 1'b0, 1'b0);
        step(2);
        rst_n = 1'b1;
        step(1);
        chk_all("rst_release", 8'h00, 1'b0, 1'b0);
        step(1);
        chk_all("rst_release2", 8'h00, 1'b0, 1'b0);

`ifdef SLEW_TICK_EXT_EN
        // 6c: external divisor 0 -> one step per clock
        tick_div    = 16'd0;
        target_duty = 8'h30;
        step(1);
        chk_all("ext_enter", 8'h00, 1'b1, 1'b0);
        step(1);
        chk_all("ext_10", 8'h10, 1'b1, 1'b0);
        step(1);
        chk_all("ext_20", 8'h20, 1'b1, 1'b0);
        step(1);
        chk_all("ext_30", 8'h30, 1'b0, 1'b1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
